// File: rtl/osd_mam_wb_sram.sv
// Purpose: Wishbone B3 slave SRAM, the byte-maskable memory behind the MAM Wishbone master.
// Latency: first beat is acked (or errored) one cycle after cyc_i&stb_i; incrementing bursts then run one beat per cycle.
// Backpressure: the master pauses a burst by dropping stb_i. That ends the burst, and the master re-requests with a fresh address.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cyc_i, stb_i, we_i      Wishbone cycle / strobe / write enable
//   addr_i, dat_i, sel_i    byte address, write data, byte enables
//   cti_i, bte_i            cycle type (000 classic, 010 incr burst, 111 end), burst type (linear/wrap4/8/16)
//   ack_o, err_o, dat_o     acknowledge, error acknowledge, registered read data
module osd_mam_wb_sram #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    MEM_WORDS  = 1024
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cyc_i,
    input  logic                    stb_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    input  logic [DATA_WIDTH/8-1:0] sel_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o,
    output logic [DATA_WIDTH-1:0]   dat_o
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int SWB = $clog2(SW);
    localparam int AW  = $clog2(MEM_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACK   = 2'd1;
    localparam logic [1:0] S_BURST = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    logic [1:0]            state;
    logic [AW-1:0]         cur_idx;
    logic [AW-1:0]         nxt_idx;
    logic [AW-1:0]         wrap_mask;
    logic [ADDR_WIDTH-1:0] off;
    logic [ADDR_WIDTH-1:0] req_idx;
    logic                  req_oor;
    logic                  lin_ovf;
    logic                  wr_en;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    always_comb begin
        off     = addr_i - BASE_ADDR;
        req_idx = off >> SWB;
        // The wrapped offset also catches addresses below BASE_ADDR, but the explicit compare keeps intent obvious.
        req_oor = (addr_i < BASE_ADDR) || (req_idx >= ADDR_WIDTH'(MEM_WORDS));

        wrap_mask = '0;
        case (bte_i)
            2'b01:   wrap_mask = AW'(3);
            2'b10:   wrap_mask = AW'(7);
            2'b11:   wrap_mask = AW'(15);
            default: wrap_mask = '0;
        endcase

        if (bte_i == 2'b00) begin
            nxt_idx = cur_idx + AW'(1);
        end else begin
            nxt_idx = (cur_idx & ~wrap_mask) | ((cur_idx + AW'(1)) & wrap_mask);
        end

        // A linear burst that would step past the last word errors its next beat instead of wrapping.
        lin_ovf = (bte_i == 2'b00) && (cur_idx == AW'(MEM_WORDS - 1));

        // Writes commit only on a completing acked beat; the reset edge itself never commits.
        wr_en = cyc_i & stb_i & ack_o & we_i & ~rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < SW; k++) begin
                if (sel_i[k]) begin
                    mem[cur_idx][8*k +: 8] <= dat_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            ack_o   <= 1'b0;
            err_o   <= 1'b0;
            dat_o   <= '0;
            cur_idx <= '0;
        end else if (!cyc_i) begin
            state <= S_IDLE;
            ack_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (stb_i) begin
                        if (req_oor) begin
                            err_o <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            cur_idx <= req_idx[AW-1:0];
                            dat_o   <= mem[req_idx[AW-1:0]];
                            ack_o   <= 1'b1;
                            state   <= (cti_i == 3'b010) ? S_BURST : S_ACK;
                        end
                    end
                end
                S_ACK: begin
                    // Forces at least one idle cycle between classic transfers.
                    ack_o <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    err_o <= 1'b0;
                    state <= S_IDLE;
                end
                S_BURST: begin
                    if (!stb_i) begin
                        // Master wait: no transfer, index holds, burst is abandoned.
                        ack_o <= 1'b0;
                        state <= S_IDLE;
                    end else if (cti_i != 3'b010) begin
                        // End-of-burst (or a non-burst code) completes this beat and stops.
                        ack_o <= 1'b0;
                        state <= S_IDLE;
                    end else if (lin_ovf) begin
                        ack_o <= 1'b0;
                        err_o <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        cur_idx <= nxt_idx;
                        dat_o   <= mem[nxt_idx];
                    end
                end
                default: begin
                    ack_o <= 1'b0;
                    err_o <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_osd_mam_wb_sram.sv
// Purpose: self-checking bench for osd_mam_wb_sram (16-bit, base 0x1000, 256 words).
// Latency: inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: exercises stb_i drops, cyc_i aborts and reset mid-burst.
module tb_osd_mam_wb_sram;

    localparam logic [31:0] BASE  = 32'h1000;
    localparam int          WORDS = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] dat_w = '0;
    logic [1:0]  sel = '0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic        ack;
    logic        err;
    logic [15:0] dat_r;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [WORDS];
    logic [15:0] rd_q [$];

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [15:0] d;
        logic [1:0]  s;
        logic        exp_err;
        logic        chk_d;
        logic [15:0] exp_d;
    } vec_t;

    vec_t vt [15];

    always #5 clk = ~clk;

    osd_mam_wb_sram #(
        .DATA_WIDTH(16),
        .ADDR_WIDTH(32),
        .BASE_ADDR (32'h1000),
        .MEM_WORDS (256)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cyc_i (cyc),
        .stb_i (stb),
        .we_i  (we),
        .addr_i(addr),
        .dat_i (dat_w),
        .sel_i (sel),
        .cti_i (cti),
        .bte_i (bte),
        .ack_o (ack),
        .err_o (err),
        .dat_o (dat_r)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic is_oor(input logic [31:0] a);
        return (a < BASE) || (((a - BASE) >> 1) >= 32'(WORDS));
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - BASE) >> 1);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] s);
        logic [15:0] r;
        r = o;
        if (s[0]) r[7:0]  = n[7:0];
        if (s[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    function automatic logic pick_we(input int mode);
        if (mode == 2) return 1'($urandom_range(0, 1));
        return (mode == 1);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return BASE - 32'($urandom_range(1, 64));
        if (r == 1) return BASE + 32'h200 + 32'($urandom_range(0, 64));
        return BASE + 32'($urandom_range(0, 511));
    endfunction

    task automatic set_bus(input logic c, input logic s, input logic w, input logic [31:0] a,
                           input logic [15:0] d, input logic [1:0] se, input logic [2:0] ct, input logic [1:0] bt);
        cyc = c; stb = s; we = w; addr = a; dat_w = d; sel = se; cti = ct; bte = bt;
    endtask

    task automatic idle_bus();
        set_bus(1'b0, 1'b0, 1'b0, 32'h0, 16'h0, 2'b00, 3'b000, 2'b00);
    endtask

    // Classic single transfer; called just after a rising edge with the bus idle.
    task automatic classic(input logic w, input logic [31:0] a, input logic [15:0] d, input logic [1:0] s,
                           input logic exp_err, input logic chk_d, input logic [15:0] exp_d);
        set_bus(1'b1, 1'b1, w, a, d, s, 3'b000, 2'b00);
        @(negedge clk); chk("cls_lat", {ack, err}, 2'b00);
        @(negedge clk); chk("cls_resp", {ack, err}, exp_err ? 2'b01 : 2'b10);
        if (chk_d) chk("cls_dat", dat_r, exp_d);
        @(posedge clk); #1;
        if (w && !is_oor(a)) ref_mem[idx_of(a)] = merge(ref_mem[idx_of(a)], d, s);
        idle_bus();
        @(negedge clk); chk("cls_end", {ack, err}, 2'b00);
        @(posedge clk); #1;
    endtask

    task automatic read_chk(input logic [31:0] a);
        classic(1'b0, a, 16'h0, 2'b00, 1'b0, 1'b1, ref_mem[idx_of(a)]);
    endtask

    // Incrementing burst of n beats (mode 0 read, 1 write, 2 mixed); the model walks the address sequence.
    task automatic burst(input logic [31:0] a, input logic [1:0] bt, input int n, input int mode);
        int idx;
        int nw;
        logic bad;
        logic w;
        logic [15:0] d;
        logic [1:0] s;
        bad = is_oor(a);
        idx = bad ? 0 : idx_of(a);
        w = pick_we(mode); d = 16'($urandom); s = 2'($urandom);
        set_bus(1'b1, 1'b1, w, a, d, s, (n == 1) ? 3'b111 : 3'b010, bt);
        rd_q.delete();
        @(negedge clk); chk("bst_lat", {ack, err}, 2'b00);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bad) begin
                chk($sformatf("bst_err[%0d]", i), {ack, err}, 2'b01);
                @(posedge clk); #1;
                break;
            end
            chk($sformatf("bst_ack[%0d]", i), {ack, err}, 2'b10);
            if (!w) begin
                chk($sformatf("bst_dat[%0d]", i), dat_r, ref_mem[idx]);
                rd_q.push_back(dat_r);
            end
            @(posedge clk); #1;
            if (w) ref_mem[idx] = merge(ref_mem[idx], d, s);
            if (bt == 2'b00) begin
                idx = idx + 1;
            end else begin
                nw  = 2 << bt;
                idx = (idx / nw) * nw + (idx + 1) % nw;
            end
            bad = (idx >= WORDS);
            if (i < n - 1) begin
                w = pick_we(mode); d = 16'($urandom); s = 2'($urandom);
                set_bus(1'b1, 1'b1, w, BASE + 32'(idx * 2), d, s, (i + 1 == n - 1) ? 3'b111 : 3'b010, bt);
            end
        end
        idle_bus();
        @(negedge clk); chk("bst_end", {ack, err}, 2'b00);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] exp_w [4];
        logic [15:0] junk;
        logic [31:0] ra;
        logic        rw;

        vt[0]  = '{1'b1, 32'h1004, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0};
        vt[1]  = '{1'b0, 32'h1004, 16'h0,    2'b00, 1'b0, 1'b1, 16'hBEEF};
        vt[2]  = '{1'b1, 32'h1004, 16'h0012, 2'b01, 1'b0, 1'b0, 16'h0};
        vt[3]  = '{1'b0, 32'h1004, 16'h0,    2'b00, 1'b0, 1'b1, 16'hBE12};
        vt[4]  = '{1'b1, 32'h1004, 16'hFFFF, 2'b00, 1'b0, 1'b0, 16'h0};
        vt[5]  = '{1'b0, 32'h1004, 16'h0,    2'b00, 1'b0, 1'b1, 16'hBE12};
        vt[6]  = '{1'b1, 32'h0FFE, 16'h1111, 2'b11, 1'b1, 1'b0, 16'h0};
        vt[7]  = '{1'b0, 32'h1200, 16'h0,    2'b00, 1'b1, 1'b0, 16'h0};
        vt[8]  = '{1'b1, 32'h1200, 16'h2222, 2'b11, 1'b1, 1'b0, 16'h0};
        vt[9]  = '{1'b0, 32'h0FFF, 16'h0,    2'b00, 1'b1, 1'b0, 16'h0};
        vt[10] = '{1'b1, 32'h1003, 16'h1234, 2'b11, 1'b0, 1'b0, 16'h0};
        vt[11] = '{1'b0, 32'h1002, 16'h0,    2'b00, 1'b0, 1'b1, 16'h1234};
        vt[12] = '{1'b1, 32'h11FE, 16'h55AA, 2'b11, 1'b0, 1'b0, 16'h0};
        vt[13] = '{1'b0, 32'h11FF, 16'h0,    2'b00, 1'b0, 1'b1, 16'h55AA};
        vt[14] = '{1'b0, 32'h1004, 16'h0,    2'b00, 1'b0, 1'b1, 16'hBE12};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_resp", {ack, err}, 2'b00);
        chk("rst_dat", dat_r, 16'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); chk("post_rst_resp", {ack, err}, 2'b00);
        @(posedge clk); #1;

        // Fill the whole array with a 256-beat linear write burst so every later read is predictable.
        burst(BASE, 2'b00, WORDS, 1);

        // Classic table: write/read, byte masks, out-of-range, ignored low address bit, last word.
        for (int i = 0; i < 15; i++) begin
            classic(vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].exp_err, vt[i].chk_d, vt[i].exp_d);
        end

        // Wrap4 read burst starting mid-block.
        classic(1'b1, 32'h1008, 16'h00A4, 2'b11, 1'b0, 1'b0, 16'h0);
        classic(1'b1, 32'h100A, 16'h00A5, 2'b11, 1'b0, 1'b0, 16'h0);
        classic(1'b1, 32'h100C, 16'h00A6, 2'b11, 1'b0, 1'b0, 16'h0);
        classic(1'b1, 32'h100E, 16'h00A7, 2'b11, 1'b0, 1'b0, 16'h0);
        burst(32'h100C, 2'b01, 4, 0);
        exp_w[0] = 16'h00A6; exp_w[1] = 16'h00A7; exp_w[2] = 16'h00A4; exp_w[3] = 16'h00A5;
        chk("wrap4_len", 32'(rd_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rd_q.size()) chk($sformatf("wrap4_seq[%0d]", i), rd_q[i], exp_w[i]);
        end

        // Linear write burst running off the end: third beat must error.
        burst(32'h11FC, 2'b00, 3, 1);
        read_chk(32'h11FC);
        read_chk(32'h11FE);

        // stb_i dropped during the second beat of a linear read burst.
        set_bus(1'b1, 1'b1, 1'b0, 32'h1020, 16'h0, 2'b00, 3'b010, 2'b00);
        @(negedge clk); chk("stb_lat", {ack, err}, 2'b00);
        @(negedge clk); chk("stb_b1_resp", {ack, err}, 2'b10);
        chk("stb_b1_dat", dat_r, ref_mem[16]);
        @(posedge clk); #1;
        stb = 1'b0; addr = 32'h1022;
        @(negedge clk); chk("stb_wait_resp", {ack, err}, 2'b10);
        @(posedge clk); #1;
        stb = 1'b1; cti = 3'b000;
        @(negedge clk); chk("stb_drop_resp", {ack, err}, 2'b00);
        @(negedge clk); chk("stb_rereq_resp", {ack, err}, 2'b10);
        chk("stb_rereq_dat", dat_r, ref_mem[17]);
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk); chk("stb_end", {ack, err}, 2'b00);
        @(posedge clk); #1;

        // cyc_i dropped during the second beat of a write burst: that write is discarded.
        set_bus(1'b1, 1'b1, 1'b1, 32'h1040, 16'h1357, 2'b11, 3'b010, 2'b00);
        @(negedge clk); chk("cyc_lat", {ack, err}, 2'b00);
        @(negedge clk); chk("cyc_b1_resp", {ack, err}, 2'b10);
        @(posedge clk); #1;
        ref_mem[32] = 16'h1357;
        junk = ~ref_mem[33];
        set_bus(1'b0, 1'b0, 1'b1, 32'h1042, junk, 2'b11, 3'b010, 2'b00);
        @(negedge clk);
        @(negedge clk); chk("cyc_drop_resp", {ack, err}, 2'b00);
        @(posedge clk); #1;
        idle_bus();
        read_chk(32'h1040);
        read_chk(32'h1042);

        // Reset during beat 3 of an 8-beat write burst.
        set_bus(1'b1, 1'b1, 1'b1, 32'h1080, 16'hC0DE, 2'b11, 3'b010, 2'b00);
        @(negedge clk); chk("rstb_lat", {ack, err}, 2'b00);
        @(negedge clk); chk("rstb_b1_resp", {ack, err}, 2'b10);
        @(posedge clk); #1;
        ref_mem[64] = 16'hC0DE;
        set_bus(1'b1, 1'b1, 1'b1, 32'h1082, 16'hF00D, 2'b11, 3'b010, 2'b00);
        @(negedge clk); chk("rstb_b2_resp", {ack, err}, 2'b10);
        @(posedge clk); #1;
        ref_mem[65] = 16'hF00D;
        junk = ~ref_mem[66];
        set_bus(1'b1, 1'b1, 1'b1, 32'h1084, junk, 2'b11, 3'b010, 2'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_bus();
        @(negedge clk);
        chk("rstb_resp", {ack, err}, 2'b00);
        chk("rstb_dat", dat_r, 16'h0);
        @(posedge clk); #1;
        read_chk(32'h1080);
        read_chk(32'h1082);
        read_chk(32'h1084);

        // Randomized classic and burst traffic against the model.
        for (int n = 0; n < 120; n++) begin
            ra = rnd_addr();
            if ($urandom_range(0, 1) == 0) begin
                rw = 1'($urandom_range(0, 1));
                classic(rw, ra, 16'($urandom), 2'($urandom), is_oor(ra), !rw && !is_oor(ra),
                        is_oor(ra) ? 16'h0 : ref_mem[idx_of(ra)]);
            end else begin
                burst(ra, 2'($urandom), $urandom_range(2, 9), $urandom_range(0, 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/osd_mam_wb_sram.md
Name: osd_mam_wb_sram

Overview:
- Wishbone B3 slave memory, directly downstream of the MAM Wishbone master (stb/cyc/we/addr/dat/cti/bte/sel).
- Provides a single-port, byte-maskable on-chip SRAM region that the debug MAM reads and writes.
- Supports classic cycles, plus registered-feedback incrementing bursts with linear or wrapping address sequences.
- Used as the system-memory target in MAM subsystem integration and as the golden memory in MAM testbenches.

Parameters:
- DATA_WIDTH, 16, word width in bits; legal values 8/16/32. SW = DATA_WIDTH/8 is the byte-select width.
- ADDR_WIDTH, 32, byte-address width.
- BASE_ADDR, 0, byte address of word 0; must be SW-aligned.
- MEM_WORDS, 1024, depth in words; power of two, ≥16. AW = log2(MEM_WORDS).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- cyc_i  in  1  bus cycle active.
- stb_i  in  1  strobe.
- we_i  in  1  1 = write.
- addr_i  in  ADDR_WIDTH  byte address.
- dat_i  in  DATA_WIDTH  write data.
- sel_i  in  SW  byte enables; bit k covers bits [8k+7:8k].
- cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst. Other codes are treated as classic.
- bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- ack_o  out  1  transfer acknowledge.
- err_o  out  1  error acknowledge.
- dat_o  out  DATA_WIDTH  read data.

Behaviour:
- Clocking and reset:
  - One clock, clk_i. Reset rst_i is synchronous and active-high.
  - Reset values: ack_o=0, err_o=0, dat_o=0, state=IDLE.
  - The memory array is not reset.
- Address decode:
  - off = addr_i − BASE_ADDR (ADDR_WIDTH arithmetic); idx = off >> log2(SW).
  - Out of range when addr_i < BASE_ADDR or idx ≥ MEM_WORDS.
  - Low log2(SW) address bits are ignored.
- Beat definition: a beat completes on a rising edge where cyc_i & stb_i & (ack_o | err_o).
- Writes:
  - Committed at the completing edge of a beat with we_i=1 and ack_o=1.
  - Only bytes with sel_i[k]=1 are written.
- Reads:
  - dat_o holds mem[cur_idx], registered and valid whenever ack_o=1 with we_i=0.
  - dat_o keeps its last value when ack_o=0.
- State machine, states IDLE / ACK / BURST / ERR:
  - IDLE, on cyc_i & stb_i:
    - Out of range: go to ERR, err_o=1 next cycle.
    - Otherwise: latch cur_idx=idx, load dat_o=mem[idx], ack_o=1 next cycle.
    - Go to BURST if cti_i==010, else ACK.
    - First-beat latency is exactly 1 cycle.
  - ACK: single-cycle ack_o, then IDLE with ack_o=0. Guarantees ≥1 idle cycle between classic transfers.
  - ERR: single-cycle err_o, then IDLE. No memory change.
  - BURST: ack_o stays high; one beat per cycle.
    - On each completing beat, cur_idx advances:
      - Linear: cur_idx+1.
      - Wrap N: (cur_idx & ~(N−1)) | ((cur_idx+1) & (N−1)).
    - dat_o is loaded with mem[next cur_idx] at the same edge.
    - If the beat carries cti_i==111: ack_o=0 next cycle, go to IDLE.
    - Linear increment past MEM_WORDS−1: the next beat presents err_o=1 instead of ack_o, then IDLE.
- Master wait and abort:
  - stb_i=0 while ack_o=1 in BURST: no transfer; cur_idx holds; ack_o=0 next cycle; go to IDLE. The master re-requests with a fresh addr_i.
  - cyc_i=0 in any state: ack_o=err_o=0 next cycle, state IDLE. In-flight writes not yet acknowledged are discarded.
- ack_o and err_o are never both 1.
- we_i is sampled per beat, so mixed bursts are accepted.
- Reset mid-burst: next cycle ack_o=0, state IDLE. Memory keeps all beats committed before the reset edge.

Test Plan:
Config for all scenarios: DATA_WIDTH=16, BASE_ADDR=0x1000, MEM_WORDS=256.
1. Classic write addr 0x1004, dat 0xBEEF, sel 11 → ack_o high exactly 1 cycle, 1 cycle after stb_i. Then classic read 0x1004 → dat_o=0xBEEF with ack_o.
2. Byte write 0x1004, dat 0x0012, sel 01 → read returns 0xBE12. Then sel 00 write of 0xFFFF → still 0xBE12.
3. Prefill words 4..7 = 0xA4..0xA7. Wrap4 read burst (bte 01) from 0x100C, 4 beats, last with cti 111 → dat_o sequence 0xA6, 0xA7, 0xA4, 0xA5, ack_o contiguous for 4 cycles, then 0.
4. Access 0x0FFE and 0x1200 → err_o one-cycle pulse each, ack_o never asserted, memory unchanged. Linear write burst from 0x11FC (idx 254) → beats 254, 255 acked; third beat gets err_o.
5. Mid-burst disruptions:
   - stb_i dropped during beat 2 of a linear read → ack_o low next cycle, no index advance; a new request at beat-2 address returns the correct data.
   - cyc_i dropped → idle next cycle.
6. rst_i asserted during beat 3 of an 8-beat write burst → ack_o=0 next cycle; words for beats 1–2 are written, beats ≥3 untouched; next classic read responds normally.
